// File: rtl/seq_detector_param_if.sv
// Purpose : bundles the serial stream, configuration and status signals of seq_detector_param.
// Latency : n/a (wiring only).
// Backpr. : none; x is sampled only when x_valid is high, the detector never stalls the source.
// Signals : x/x_valid (stream in), cfg_load/cfg_pattern/overlap/clr_count (control),
//           y_mealy/y/match_count/armed (detector outputs).
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             overlap;
    logic             clr_count;
    logic             y_mealy;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    // Stream source / controller side.
    modport master (
        output x, x_valid, cfg_load, cfg_pattern, overlap, clr_count,
        input  y_mealy, y, match_count, armed
    );

    // Detector side.
    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, overlap, clr_count,
        output y_mealy, y, match_count, armed
    );
endinterface

// File: rtl/seq_detector_param.sv
// Purpose : serial bit-pattern detector with Mealy flag, registered flag and saturating match count.
// Latency : y_mealy same cycle as the completing bit; y / match_count one cycle later.
// Backpr. : none; x_valid gaps simply hold history, the stream is never throttled.
// Ports   : clk, rst (sync, active-high); bus (slave modport of seq_detector_param_if):
//           x, x_valid, cfg_load, cfg_pattern, overlap, clr_count in;
//           y_mealy, y, match_count, armed out.
module seq_detector_param #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
    parameter int               CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int               FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);

    // FILLING until a full window of history is held, then ARMED.
    typedef enum logic {S_FILLING = 1'b0, S_ARMED = 1'b1} state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nx;
    logic [PAT_W-1:0] w_pat_nx;
    logic [PAT_W-1:0] w_hist_nx;
    logic [FW-1:0]    w_fill_nx;
    logic             w_y_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    logic [PAT_W-1:0] w_win;
    logic [FW-1:0]    w_fill_inc;
    logic             w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILLING;
            r_pat   <= PAT_INIT;
            r_hist  <= '0;
            r_fill  <= '0;
            r_y     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pat   <= w_pat_nx;
            r_hist  <= w_hist_nx;
            r_fill  <= w_fill_nx;
            r_y     <= w_y_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_pat_nx   = r_pat;
        w_hist_nx  = r_hist;
        w_fill_nx  = r_fill;
        w_y_nx     = 1'b0;
        w_cnt_nx   = r_cnt;
        w_state_nx = r_state;

        // Window as it would look with the current bit shifted in.
        w_win      = {r_hist[PAT_W-2:0], bus.x};
        w_fill_inc = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + 1'b1;
        // A load cycle discards x, so it can never complete a match.
        w_match    = bus.x_valid & ~bus.cfg_load & (w_fill_inc == FILL_MAX) & (w_win == r_pat);

        if (bus.cfg_load) begin
            w_pat_nx  = bus.cfg_pattern;
            w_hist_nx = '0;
            w_fill_nx = '0;
        end else if (bus.x_valid) begin
            w_hist_nx = w_win;
            // Non-overlap mode demands PAT_W fresh bits after a hit; old
            // history bits are all shifted out by the time fill is full again.
            w_fill_nx = (w_match && !bus.overlap) ? '0 : w_fill_inc;
            w_y_nx    = w_match;
        end

        // Clear beats a coincident match; otherwise saturate at all-ones.
        if (bus.clr_count) begin
            w_cnt_nx = '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nx = r_cnt + 1'b1;
        end

        w_state_nx = (w_fill_nx == FILL_MAX) ? S_ARMED : S_FILLING;
    end

    assign bus.y_mealy     = w_match;
    assign bus.y           = r_y;
    assign bus.match_count = r_cnt;
    assign bus.armed       = (r_state == S_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Purpose : self-checking bench for seq_detector_param (PAT_W=4, CNT_W=2 so saturation is reachable).
// Latency : expectations queued at drive time; Mealy checked mid-cycle, registered outputs after the edge.
// Backpr. : n/a.
module tb_seq_detector_param;
    localparam int             PW    = 4;
    localparam int             CW    = 2;
    localparam logic [PW-1:0]  PINIT = 4'b1011;

    typedef struct packed {
        logic          y;
        logic [CW-1:0] cnt;
        logic          armed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_detector_param_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    seq_detector_param #(.PAT_W(PW), .PAT_INIT(PINIT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: list of bits consumed since the last restart.
    bit            m_bits[$];
    logic [PW-1:0] m_pat = PINIT;
    int            m_cnt = 0;
    bit            g_ov  = 1'b1;

    bit   q_m[$];
    exp_t q_r[$];

    int n_pass = 0;
    int n_total = 0;
    int n_mealy_hits = 0;
    int n_y_hits = 0;

    // Applies one cycle of inputs, records what the DUT must show, then
    // returns just after the consuming clock edge.
    task automatic drive(input bit xi, input bit xv, input bit ld = 1'b0,
                         input logic [PW-1:0] pat = '0, input bit clr = 1'b0,
                         input bit r = 1'b0);
        bit            mm;
        logic [PW-1:0] w;
        exp_t          e;
        rst             = r;
        bus.x           = xi;
        bus.x_valid     = xv;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.overlap     = g_ov;
        bus.clr_count   = clr;

        mm = 1'b0;
        if (!ld && xv && m_bits.size() >= PW - 1) begin
            w = '0;
            for (int i = 0; i < PW - 1; i++)
                w = {w[PW-2:0], m_bits[m_bits.size() - (PW - 1) + i]};
            w  = {w[PW-2:0], xi};
            mm = (w == m_pat);
        end
        q_m.push_back(mm);

        e.y = 1'b0;
        if (r) begin
            m_pat = PINIT;
            m_bits.delete();
            m_cnt = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (mm && m_cnt < (1 << CW) - 1) m_cnt++;
            if (ld) begin
                m_pat = pat;
                m_bits.delete();
            end else if (xv) begin
                m_bits.push_back(xi);
                if (m_bits.size() > PW) void'(m_bits.pop_front());
                if (mm && !g_ov) m_bits.delete();
                e.y = mm;
            end
        end
        e.cnt   = m_cnt[CW-1:0];
        e.armed = (m_bits.size() >= PW);
        q_r.push_back(e);

        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // Scoreboard: pops the Mealy expectation mid-cycle and the registered
    // expectation just after the edge that consumed the stimulus.
    task automatic monitor();
        bit   em;
        exp_t er;
        forever begin
            @(negedge clk);
            if (q_m.size() != 0) begin
                em = q_m.pop_front();
                n_total++;
                if (bus.y_mealy !== em)
                    $display("FAIL sb_y_mealy t=%0t got %b exp %b", $time, bus.y_mealy, em);
                else n_pass++;
                if (bus.y_mealy === 1'b1) n_mealy_hits++;
            end
            @(posedge clk);
            #1;
            if (q_r.size() != 0) begin
                er = q_r.pop_front();
                n_total++;
                if (bus.y !== er.y)
                    $display("FAIL sb_y t=%0t got %b exp %b", $time, bus.y, er.y);
                else n_pass++;
                n_total++;
                if (bus.match_count !== er.cnt)
                    $display("FAIL sb_count t=%0t got %0d exp %0d", $time, bus.match_count, er.cnt);
                else n_pass++;
                n_total++;
                if (bus.armed !== er.armed)
                    $display("FAIL sb_armed t=%0t got %b exp %b", $time, bus.armed, er.armed);
                else n_pass++;
                if (bus.y === 1'b1) n_y_hits++;
            end
        end
    endtask

    task automatic restart(input bit ov);
        g_ov = ov;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_mealy_hits = 0;
        n_y_hits     = 0;
    endtask

    task automatic test_reset();
        restart(1'b1);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_total++;
        if (bus.y !== 1'b0 || bus.match_count !== 2'd0 || bus.armed !== 1'b0)
            $display("FAIL reset_state got y=%b cnt=%0d armed=%b exp 0/0/0", bus.y, bus.match_count, bus.armed);
        else n_pass++;
    endtask

    task automatic test_overlap();
        restart(1'b1);
        send(16'b1011011, 7);
        n_total++;
        if (n_mealy_hits != 2 || n_y_hits != 2)
            $display("FAIL ovl_hits got mealy=%0d y=%0d exp 2/2", n_mealy_hits, n_y_hits);
        else n_pass++;
        n_total++;
        if (bus.match_count !== 2'd2)
            $display("FAIL ovl_count got %0d exp 2", bus.match_count);
        else n_pass++;
    endtask

    task automatic test_no_overlap();
        restart(1'b0);
        send(16'b1011, 4);
        n_total++;
        if (bus.armed !== 1'b0 || bus.y !== 1'b1)
            $display("FAIL novl_after_hit got armed=%b y=%b exp 0/1", bus.armed, bus.y);
        else n_pass++;
        send(16'b011, 3);
        n_total++;
        if (bus.match_count !== 2'd1 || n_mealy_hits != 1)
            $display("FAIL novl_count got cnt=%0d hits=%0d exp 1/1", bus.match_count, n_mealy_hits);
        else n_pass++;
    endtask

    task automatic test_gap();
        restart(1'b1);
        send(16'b10, 2);
        idle(5);
        n_total++;
        if (bus.armed !== 1'b0 || n_mealy_hits != 0)
            $display("FAIL gap_hold got armed=%b hits=%0d exp 0/0", bus.armed, n_mealy_hits);
        else n_pass++;
        send(16'b11, 2);
        idle(1);
        n_total++;
        if (n_y_hits != 1 || bus.match_count !== 2'd1)
            $display("FAIL gap_match got y_hits=%0d cnt=%0d exp 1/1", n_y_hits, bus.match_count);
        else n_pass++;
    endtask

    task automatic test_cfg_load();
        restart(1'b1);
        send(16'b011, 3);
        drive(1'b0, 1'b1, 1'b1, 4'b0110);
        n_total++;
        if (n_mealy_hits != 0 || bus.armed !== 1'b0)
            $display("FAIL load_cycle got hits=%0d armed=%b exp 0/0", n_mealy_hits, bus.armed);
        else n_pass++;
        send(16'b011, 3);
        n_total++;
        if (bus.armed !== 1'b0)
            $display("FAIL load_fill got armed=%b exp 0", bus.armed);
        else n_pass++;
        send(16'b0, 1);
        n_total++;
        if (bus.armed !== 1'b1 || n_mealy_hits != 1 || bus.y !== 1'b1)
            $display("FAIL load_match got armed=%b hits=%0d y=%b exp 1/1/1", bus.armed, n_mealy_hits, bus.y);
        else n_pass++;
    endtask

    task automatic test_saturate_clear();
        restart(1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'b1111);
        send(16'b1111111, 7);
        n_total++;
        if (bus.match_count !== 2'd3 || n_mealy_hits != 4)
            $display("FAIL sat_count got cnt=%0d hits=%0d exp 3/4", bus.match_count, n_mealy_hits);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        n_total++;
        if (bus.match_count !== 2'd0 || bus.y !== 1'b1)
            $display("FAIL clr_wins got cnt=%0d y=%b exp 0/1", bus.match_count, bus.y);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        restart(1'b1);
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        send(16'b0000, 4);
        n_total++;
        if (bus.match_count !== 2'd1)
            $display("FAIL zero_pat got cnt=%0d exp 1", bus.match_count);
        else n_pass++;
        send(16'b00, 2);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_total++;
        if (bus.y !== 1'b0 || bus.match_count !== 2'd0 || bus.armed !== 1'b0)
            $display("FAIL mid_reset got y=%b cnt=%0d armed=%b exp 0/0/0", bus.y, bus.match_count, bus.armed);
        else n_pass++;
        n_mealy_hits = 0;
        send(16'b1011, 4);
        n_total++;
        if (n_mealy_hits != 1 || bus.match_count !== 2'd1)
            $display("FAIL init_restored got hits=%0d cnt=%0d exp 1/1", n_mealy_hits, bus.match_count);
        else n_pass++;
    endtask

    initial begin
        bus.x           = 1'b0;
        bus.x_valid     = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.overlap     = 1'b1;
        bus.clr_count   = 1'b0;
        fork
            monitor();
        join_none
        @(posedge clk);
        #2;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_gap();
        test_cfg_load();
        test_saturate_clear();
        test_reset_midstream();
        idle(2);
        n_total++;
        if (q_r.size() != 0 || q_m.size() != 0)
            $display("FAIL sb_drain got %0d/%0d pending exp 0/0", q_m.size(), q_r.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
